// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS32 core: sequences the shared memory port,
// register file, ALU and PC. It also handles memory wait states, timeouts and retired-instruction counting.
module mips_multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             reg_write,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic [3:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT - 1);

  state_t           state_r, state_nxt_s;
  logic [7:0]       wait_cnt_r, wait_cnt_nxt_s;
  logic             mem_timeout_r;
  logic [CNT_W-1:0] instr_count_r;
  logic             in_wait_s, abort_s, retire_s;
  logic             pc_write_s, pc_write_cond_s, ir_write_s, reg_write_s, mem_write_s;
  logic             alu_zero_unused_s;

  // alu_zero qualifies pc_write_cond in the datapath, not here
  assign alu_zero_unused_s = alu_zero;

  assign in_wait_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
  assign abort_s   = in_wait_s && !mem_ready && (wait_cnt_r == WAIT_LIM);

  // Next-state and control decode
  always_comb begin
    state_nxt_s     = state_r;
    retire_s        = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    mem_write_s     = 1'b0;
    iord            = 1'b0;
    mem_read        = 1'b0;
    regdst          = 2'b00;
    memtoreg        = 2'b00;
    alusrca         = 1'b0;
    alusrcb         = 2'b00;
    aluop           = 2'b00;
    pcsrc           = 2'b00;
    case (state_r)
      S_FETCH: begin
        mem_read = 1'b1;
        alusrcb  = 2'b01;
        if (mem_ready) begin
          ir_write_s  = 1'b1;
          pc_write_s  = 1'b1;
          state_nxt_s = S_DECODE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_nxt_s = S_MEMADR;
          OP_RTYPE:     state_nxt_s = S_EXEC;
          OP_BEQ:       state_nxt_s = S_BRANCH;
          OP_J:         state_nxt_s = S_JUMP;
          OP_JAL:       state_nxt_s = S_JAL;
          OP_ADDI:      state_nxt_s = S_ADDIEX;
          default:      state_nxt_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (opcode == OP_LW) begin
          state_nxt_s = S_MEMRD;
        end else begin
          state_nxt_s = S_MEMWR;
        end
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_nxt_s = S_MEMWB;
        end else if (abort_s) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        reg_write_s = 1'b1;
        memtoreg    = 2'b01;
        retire_s    = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        iord        = 1'b1;
        if (mem_ready) begin
          retire_s    = 1'b1;
          state_nxt_s = S_FETCH;
        end else if (abort_s) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_MEMWR;
        end
      end
      S_EXEC: begin
        alusrca     = 1'b1;
        aluop       = 2'b10;
        state_nxt_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        regdst      = 2'b01;
        retire_s    = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_BRANCH: begin
        alusrca         = 1'b1;
        aluop           = 2'b01;
        pcsrc           = 2'b01;
        pc_write_cond_s = 1'b1;
        retire_s        = 1'b1;
        state_nxt_s     = S_FETCH;
      end
      S_JUMP: begin
        pcsrc       = 2'b10;
        pc_write_s  = 1'b1;
        retire_s    = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_JAL: begin
        pcsrc       = 2'b10;
        pc_write_s  = 1'b1;
        reg_write_s = 1'b1;
        regdst      = 2'b10;
        memtoreg    = 2'b10;
        retire_s    = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca     = 1'b1;
        alusrcb     = 2'b10;
        state_nxt_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_nxt_s = S_FETCH;
      end
      default: state_nxt_s = S_FETCH;
    endcase
  end

  // Wait counter restarts whenever memory answers or the wait is abandoned
  always_comb begin
    if (in_wait_s && !mem_ready && !abort_s) begin
      wait_cnt_nxt_s = wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_nxt_s = 8'd0;
    end
  end

  // Strobes are held low combinationally while reset is asserted
  assign pc_write      = pc_write_s      & rst;
  assign pc_write_cond = pc_write_cond_s & rst;
  assign ir_write      = ir_write_s      & rst;
  assign reg_write     = reg_write_s     & rst;
  assign mem_write     = mem_write_s     & rst;
  assign state         = state_r;
  assign mem_timeout   = mem_timeout_r;
  assign instr_count   = instr_count_r;

  // State, wait counter, timeout pulse and retire counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= S_FETCH;
      wait_cnt_r    <= 8'd0;
      mem_timeout_r <= 1'b0;
      instr_count_r <= '0;
    end else begin
      state_r       <= state_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      mem_timeout_r <= abort_s;
      if (retire_s) begin
        instr_count_r <= instr_count_r + CNT_W'(1);
      end else begin
        instr_count_r <= instr_count_r;
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: an instruction-level model expands each opcode
// into its step sequence, applies memory waits/timeouts and predicts every output per cycle.
module tb_mips_multicycle_ctrl;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 32;
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6;
  localparam int ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11, JAL = 12;

  logic clk, rst, alu_zero, mem_ready;
  logic [5:0] opcode;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, alusrca;
  logic [1:0] regdst, memtoreg, alusrcb, aluop, pcsrc;
  logic [3:0] state;
  logic mem_timeout;
  logic [CNT_W-1:0] instr_count;
  logic [17:0] got_ctrl;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int path[$];
  int idx;
  bit new_instr;
  int wcnt;
  bit tmo_pend;
  logic [31:0] cnt_m;
  logic [5:0] op;
  logic [5:0] force_q[$];
  bit rdy_q[$];

  mips_multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .regdst(regdst), .memtoreg(memtoreg),
    .reg_write(reg_write), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsrc(pcsrc), .state(state), .mem_timeout(mem_timeout), .instr_count(instr_count)
  );

  assign got_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                     regdst, memtoreg, reg_write, alusrca, alusrcb, aluop, pcsrc};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control vector for a step, straight from the per-step output table
  function automatic logic [17:0] exp_ctrl(input int st, input bit rdy);
    logic pcw, pcc, io, mr, mw, irw, rw, asa;
    logic [1:0] rd, mtr, asb, aop, ps;
    pcw = 1'b0; pcc = 1'b0; io = 1'b0; mr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; asa = 1'b0;
    rd = 2'b00; mtr = 2'b00; asb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      FETCH:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
      DECODE: asb = 2'b11;
      MEMADR: begin asa = 1'b1; asb = 2'b10; end
      MEMRD:  begin mr = 1'b1; io = 1'b1; end
      MEMWB:  begin rw = 1'b1; mtr = 2'b01; end
      MEMWR:  begin mw = 1'b1; io = 1'b1; end
      EXEC:   begin asa = 1'b1; aop = 2'b10; end
      ALUWB:  begin rw = 1'b1; rd = 2'b01; end
      BRANCH: begin asa = 1'b1; aop = 2'b01; ps = 2'b01; pcc = 1'b1; end
      JUMP:   begin ps = 2'b10; pcw = 1'b1; end
      JAL:    begin ps = 2'b10; pcw = 1'b1; rw = 1'b1; rd = 2'b10; mtr = 2'b10; end
      ADDIEX: begin asa = 1'b1; asb = 2'b10; end
      ADDIWB: rw = 1'b1;
      default: ;
    endcase
    return {pcw, pcc, io, mr, mw, irw, rd, mtr, rw, asa, asb, aop, ps};
  endfunction

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 8))
      0: return 6'h23;
      1: return 6'h2b;
      2: return 6'h00;
      3: return 6'h04;
      4: return 6'h02;
      5: return 6'h03;
      6: return 6'h08;
      default: return 6'($urandom);
    endcase
  endfunction

  // Expand an opcode into the sequence of steps it walks through
  task automatic build(input logic [5:0] o);
    path.delete();
    path.push_back(FETCH);
    path.push_back(DECODE);
    case (o)
      6'h23: begin path.push_back(MEMADR); path.push_back(MEMRD); path.push_back(MEMWB); end
      6'h2b: begin path.push_back(MEMADR); path.push_back(MEMWR); end
      6'h00: begin path.push_back(EXEC); path.push_back(ALUWB); end
      6'h04: path.push_back(BRANCH);
      6'h02: path.push_back(JUMP);
      6'h03: path.push_back(JAL);
      6'h08: begin path.push_back(ADDIEX); path.push_back(ADDIWB); end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    idx = 0; new_instr = 1'b1; wcnt = 0; tmo_pend = 1'b0; cnt_m = 32'd0;
  endtask

  // Called at a negedge; leaves the bench at the next negedge
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b0;
      mem_ready = 1'b1;
      opcode = rand_op();
      alu_zero = 1'($urandom);
      #1;
      check("rst_strobes", {27'd0, pc_write, pc_write_cond, ir_write, reg_write, mem_write}, 32'd0);
      if (i > 0) begin
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_count", instr_count, 32'd0);
        check("rst_tmo", {31'd0, mem_timeout}, 32'd0);
      end
      @(negedge clk);
    end
    model_reset();
    rst = 1'b1;
  endtask

  // One clock of stimulus, comparison against the model, and model advance
  task automatic step();
    int st;
    bit rdy;
    if (idx == 0 && new_instr) begin
      if (force_q.size() > 0) op = force_q.pop_front();
      else op = rand_op();
      new_instr = 1'b0;
      build(op);
    end
    if (rdy_q.size() == 0 && $urandom_range(0, 199) == 0) begin
      for (int k = 0; k < int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1)); k++) rdy_q.push_back(1'b0);
    end
    if (rdy_q.size() > 0) rdy = rdy_q.pop_front();
    else rdy = ($urandom_range(0, 3) != 0);
    opcode = op;
    mem_ready = rdy;
    alu_zero = 1'($urandom);
    #1;
    st = path[idx];
    check("state", {28'd0, state}, st);
    check("ctrl", {14'd0, got_ctrl}, {14'd0, exp_ctrl(st, rdy)});
    check("mem_timeout", {31'd0, mem_timeout}, {31'd0, tmo_pend});
    check("instr_count", instr_count, cnt_m);
    tmo_pend = 1'b0;
    if ((st == FETCH || st == MEMRD || st == MEMWR) && !rdy) begin
      wcnt++;
      if (wcnt == TIMEOUT) begin
        wcnt = 0;
        tmo_pend = 1'b1;
        idx = 0;
        if (st != FETCH) new_instr = 1'b1;
      end
    end else begin
      wcnt = 0;
      idx++;
      if (idx == path.size()) begin
        if (path.size() > 2) cnt_m++;
        idx = 0;
        new_instr = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'd0;
    alu_zero = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // directed: R, lw with 3 waits, sw, beq, jal, illegal, FETCH timeout then j
    force_q = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h03, 6'h3f, 6'h02};
    for (int k = 0; k < 4; k++) rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1); rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0); rdy_q.push_back(1'b0); rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b1); rdy_q.push_back(1'b1);
    for (int k = 0; k < 10; k++) rdy_q.push_back(1'b1);
    for (int k = 0; k < TIMEOUT; k++) rdy_q.push_back(1'b0);
    for (int k = 0; k < 3; k++) rdy_q.push_back(1'b1);
    for (int k = 0; k < 42; k++) step();
    check("directed_count", instr_count, 32'd6);

    for (int k = 0; k < 1500; k++) step();
    do_reset(2);
    for (int k = 0; k < 400; k++) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
